// File: rtl/multiplier_pkg.sv
// ----------------------------------------------------------------------------
// Module   : multiplier_pkg
// Brief    : State encodings shared with the restoring divisor, so STATE_OUT
//            decodes identically in waveforms of both blocks.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
`default_nettype none

package multiplier_pkg;

   localparam int c_STATE_W = 3;

   typedef enum logic [c_STATE_W-1:0] {
      ST_IDLE = 3'd0,
      ST_LOAD = 3'd1,
      ST_CALC = 3'd2,
      ST_DONE = 3'd3
   } state_t;

endpackage : multiplier_pkg

`default_nettype wire

// File: rtl/multiplier_if.sv
// ----------------------------------------------------------------------------
// Module   : multiplier_if
// Brief    : Operand/result bundle of the shift-add multiplier. Carries the
//            err flag only when MULT_REMAINDER_CHECK_EN is defined.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
`default_nettype none

interface multiplier_if #(
   parameter int WIDTH = 4
);

   logic                                  en;
   logic [WIDTH-1:0]                      Q_IN;
   logic [WIDTH-1:0]                      B_IN;
   logic [WIDTH-1:0]                      R_IN;
   logic [2*WIDTH-1:0]                    P_OUT;
   logic                                  valid;
   logic                                  busy;
   logic [multiplier_pkg::c_STATE_W-1:0]  STATE_OUT;
   logic [WIDTH-1:0]                      COUNT_OUT;
`ifdef MULT_REMAINDER_CHECK_EN
   logic                                  err;

   modport master (
      output en, Q_IN, B_IN, R_IN,
      input  P_OUT, valid, busy, STATE_OUT, COUNT_OUT, err
   );

   modport slave (
      input  en, Q_IN, B_IN, R_IN,
      output P_OUT, valid, busy, STATE_OUT, COUNT_OUT, err
   );
`else
   modport master (
      output en, Q_IN, B_IN, R_IN,
      input  P_OUT, valid, busy, STATE_OUT, COUNT_OUT
   );

   modport slave (
      input  en, Q_IN, B_IN, R_IN,
      output P_OUT, valid, busy, STATE_OUT, COUNT_OUT
   );
`endif

endinterface : multiplier_if

`default_nettype wire

// File: rtl/multiplier.sv
// ----------------------------------------------------------------------------
// Module   : multiplier
// Brief    : Sequential shift-add multiplier, P = Q*B + R over WIDTH CALC
//            cycles. Optional remainder sanity flag: MULT_REMAINDER_CHECK_EN.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
`default_nettype none

module multiplier
   import multiplier_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  wire logic   clk,
   input  wire logic   rst,
   multiplier_if.slave bus
);

   localparam logic [WIDTH-1:0] c_LAST = WIDTH'(WIDTH - 1);

   state_t               r_state;
   state_t               w_state_next;
   logic                 w_valid;
   logic                 w_busy;

   logic [2*WIDTH-1:0]   r_acc;
   logic [2*WIDTH-1:0]   r_p;
   logic [WIDTH-1:0]     r_q;
   logic [WIDTH-1:0]     r_b;
   logic [WIDTH-1:0]     r_count;

   logic [2*WIDTH-1:0]   w_addend;
   logic [2*WIDTH-1:0]   w_acc_next;
   logic                 w_last;

   assign w_last = (r_count == c_LAST);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      w_valid      = 1'b0;
      w_busy       = 1'b0;
      case (r_state)
         ST_IDLE: begin
            // An X on en evaluates false here, so it never starts an operation.
            if (bus.en) begin
               w_state_next = ST_LOAD;
            end
         end
         ST_LOAD: begin
            w_busy       = 1'b1;
            w_state_next = ST_CALC;
         end
         ST_CALC: begin
            w_busy = 1'b1;
            if (w_last) begin
               w_state_next = ST_DONE;
            end
         end
         ST_DONE: begin
            w_valid      = 1'b1;
            w_state_next = ST_IDLE;
         end
         default: begin
            w_state_next = ST_IDLE;
         end
      endcase
   end

   // Every bit is visited even when Q or B is zero, keeping latency fixed.
   always_comb begin
      w_addend   = r_q[0] ? ({{WIDTH{1'b0}}, r_b} << r_count) : '0;
      w_acc_next = r_acc + w_addend;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_acc   <= '0;
         r_p     <= '0;
         r_q     <= '0;
         r_b     <= '0;
         r_count <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (bus.en) begin
                  r_q     <= bus.Q_IN;
                  r_b     <= bus.B_IN;
                  r_acc   <= {{WIDTH{1'b0}}, bus.R_IN};
                  r_count <= '0;
               end
            end
            ST_CALC: begin
               r_acc   <= w_acc_next;
               r_q     <= r_q >> 1;
               r_count <= r_count + 1'b1;
               if (w_last) begin
                  r_p <= w_acc_next;
               end
            end
            default: begin
            end
         endcase
      end
   end

`ifdef MULT_REMAINDER_CHECK_EN
   logic r_err;

   // Flags a triple no valid division could produce: B==0 or R>=B.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_err <= 1'b0;
      end else if (r_state == ST_IDLE && bus.en) begin
         r_err <= (bus.B_IN == '0) || (bus.R_IN >= bus.B_IN);
      end
   end

   assign bus.err = r_err;
`endif

   assign bus.P_OUT     = r_p;
   assign bus.valid     = w_valid;
   assign bus.busy      = w_busy;
   assign bus.STATE_OUT = r_state;
   assign bus.COUNT_OUT = r_count;

endmodule : multiplier

`default_nettype wire

// File: tb/tb_multiplier.sv
// ----------------------------------------------------------------------------
// Module   : tb_multiplier
// Brief    : Self-checking bench for multiplier (WIDTH=4); covers the
//            MULT_REMAINDER_CHECK_EN err flag when that macro is defined.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
`default_nettype none

module tb_multiplier;

   localparam int W = 4;

   typedef struct {
      string        nm;
      logic [W-1:0] q;
      logic [W-1:0] b;
      logic [W-1:0] r;
      int           p;
      bit           err;
   } vec_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;

   multiplier_if #(.WIDTH(W)) bus ();

   multiplier #(.WIDTH(W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual %0d required %0d", nm, act, exp);
      end
   endtask

   // One full operation from an idle DUT; scrambles inputs mid-CALC.
   task automatic run_op(input vec_t v);
      int n;
      @(negedge clk);
      bus.Q_IN = v.q;
      bus.B_IN = v.b;
      bus.R_IN = v.r;
      bus.en   = 1'b1;
      @(negedge clk);
      bus.en = 1'b0;
      n = 1;
      while (!bus.valid && n < 20) begin
         chk({v.nm, " state"}, 32'(bus.STATE_OUT), (n == 1) ? 32'd1 : 32'd2);
         chk({v.nm, " busy"}, 32'(bus.busy), 32'd1);
         if (n == 3) begin
            bus.Q_IN = ~v.q;
            bus.B_IN = ~v.b;
            bus.R_IN = v.r ^ 4'b0101;
         end
         @(negedge clk);
         n++;
      end
      chk({v.nm, " latency"}, 32'(n), 32'(W + 2));
      chk({v.nm, " valid"}, 32'(bus.valid), 32'd1);
      chk({v.nm, " state done"}, 32'(bus.STATE_OUT), 32'd3);
      chk({v.nm, " busy done"}, 32'(bus.busy), 32'd0);
      chk({v.nm, " P_OUT"}, 32'(bus.P_OUT), 32'(v.p));
`ifdef MULT_REMAINDER_CHECK_EN
      chk({v.nm, " err"}, 32'(bus.err), 32'(v.err));
`endif
      @(negedge clk);
      chk({v.nm, " valid drop"}, 32'(bus.valid), 32'd0);
      chk({v.nm, " state idle"}, 32'(bus.STATE_OUT), 32'd0);
      chk({v.nm, " P_OUT hold"}, 32'(bus.P_OUT), 32'(v.p));
   endtask

   vec_t tbl [8];
   vec_t v;

   initial begin
      tbl[0] = '{"basic",   4'd3,  4'd4,  4'd0,  12,  1'b0};
      tbl[1] = '{"max",     4'd15, 4'd15, 4'd15, 240, 1'b0};
      tbl[2] = '{"b_zero",  4'd5,  4'd0,  4'd7,  7,   1'b1};
      tbl[3] = '{"trip12",  4'd2,  4'd5,  4'd2,  12,  1'b0};
      tbl[4] = '{"q_zero",  4'd0,  4'd15, 4'd0,  0,   1'b0};
      tbl[5] = '{"r_only",  4'd15, 4'd0,  4'd15, 15,  1'b1};
      tbl[6] = '{"q_one",   4'd1,  4'd15, 4'd0,  15,  1'b0};
      tbl[7] = '{"mid",     4'd8,  4'd9,  4'd3,  75,  1'b0};

      bus.en   = 1'b0;
      bus.Q_IN = '0;
      bus.B_IN = '0;
      bus.R_IN = '0;

      #12;
      chk("rst state", 32'(bus.STATE_OUT), 32'd0);
      chk("rst P_OUT", 32'(bus.P_OUT), 32'd0);
      chk("rst valid", 32'(bus.valid), 32'd0);
      chk("rst busy", 32'(bus.busy), 32'd0);
      chk("rst count", 32'(bus.COUNT_OUT), 32'd0);
`ifdef MULT_REMAINDER_CHECK_EN
      chk("rst err", 32'(bus.err), 32'd0);
`endif
      #8;
      rst = 1'b0;

      foreach (tbl[i]) run_op(tbl[i]);

      // en held high across two operations
      @(negedge clk);
      bus.Q_IN = 4'd1;
      bus.B_IN = 4'd1;
      bus.R_IN = 4'd0;
      bus.en   = 1'b1;
      for (int n = 1; n <= 16; n++) begin
         @(negedge clk);
         if (n == 3) begin
            bus.Q_IN = 4'd2;
            bus.B_IN = 4'd3;
            bus.R_IN = 4'd1;
         end
         if (n == 10) begin
            bus.Q_IN = 4'd15;
            bus.B_IN = 4'd15;
            bus.R_IN = 4'd15;
         end
         chk($sformatf("b2b valid n=%0d", n), 32'(bus.valid), (n == 6 || n == 13) ? 32'd1 : 32'd0);
         if (n == 6)  chk("b2b P_OUT first", 32'(bus.P_OUT), 32'd1);
         if (n == 13) begin
            chk("b2b P_OUT second", 32'(bus.P_OUT), 32'd7);
            bus.en = 1'b0;
         end
      end

      // reset during the third CALC cycle
      @(negedge clk);
      bus.Q_IN = 4'd7;
      bus.B_IN = 4'd7;
      bus.R_IN = 4'd3;
      bus.en   = 1'b1;
      @(negedge clk);
      bus.en = 1'b0;
      repeat (3) @(negedge clk);
      chk("abort pre state", 32'(bus.STATE_OUT), 32'd2);
      rst = 1'b1;
      #1;
      chk("abort state", 32'(bus.STATE_OUT), 32'd0);
      chk("abort P_OUT", 32'(bus.P_OUT), 32'd0);
      chk("abort busy", 32'(bus.busy), 32'd0);
      chk("abort valid", 32'(bus.valid), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      for (int n = 0; n < 8; n++) begin
         @(negedge clk);
         chk("abort no valid", 32'(bus.valid), 32'd0);
         chk("abort idle", 32'(bus.STATE_OUT), 32'd0);
      end
      v = '{"post_abort", 4'd6, 4'd2, 4'd1, 13, 1'b0};
      run_op(v);

      // random operands against plain arithmetic
      for (int i = 0; i < 30; i++) begin
         v.nm  = $sformatf("rand%0d", i);
         v.q   = 4'($urandom_range(0, 15));
         v.b   = 4'($urandom_range(0, 15));
         v.r   = 4'($urandom_range(0, 15));
         v.p   = int'(v.q) * int'(v.b) + int'(v.r);
         v.err = (v.b == 0) || (v.r >= v.b);
         run_op(v);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule : tb_multiplier

`default_nettype wire
